// File: rtl/tlb_pkg.sv
// Shared types and constants for the data-TLB lookup stage.
package tlb_pkg;

  localparam int unsigned TLB_CNT_W      = 16;
  localparam int unsigned TLB_DATA_W     = 16;
  localparam int unsigned TLB_PAGE_OFF_W = 8;
  localparam int unsigned TLB_PN_W       = TLB_DATA_W - TLB_PAGE_OFF_W;

  typedef enum logic {
    LOOKUP   = 1'b0,
    MISS_REQ = 1'b1
  } tlb_state_e;

  // Entry layout for the default address split.
  typedef struct packed {
    logic                valid;
    logic [TLB_PN_W-1:0] vpn;
    logic [TLB_PN_W-1:0] ppn;
  } tlb_entry_t;

  function automatic logic [TLB_CNT_W-1:0] sat_inc(input logic [TLB_CNT_W-1:0] v);
    return (v == '1) ? v : v + TLB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// Fully associative TLB storage: parallel match, victim choice, fill port and flush.
module tlb_cam
  import tlb_pkg::*;
#(
  parameter int unsigned VPN_W   = TLB_PN_W,
  parameter int unsigned PPN_W   = TLB_PN_W,
  parameter int unsigned ENTRIES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit_c,
  output logic [PPN_W-1:0] hit_ppn_c,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  entry_t           entry_q [ENTRIES];
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] victim_c;
  logic             free_c;

  // Match: scanning downwards lets the lowest matching index win.
  always_comb begin
    hit_c     = 1'b0;
    hit_ppn_c = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_q[i].valid && (entry_q[i].vpn == lookup_vpn)) begin
        hit_c     = 1'b1;
        hit_ppn_c = entry_q[i].ppn;
      end
    end
  end

  // Victim: lowest free slot, else the round-robin slot.
  always_comb begin
    free_c   = 1'b0;
    victim_c = rr_ptr_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) begin
        free_c   = 1'b1;
        victim_c = IDX_W'(i);
      end
    end
  end

  // Flush outranks a fill in the same cycle so a stale translation never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
      rr_ptr_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) entry_q[i].valid <= 1'b0;
      rr_ptr_q <= '0;
    end else if (wr_en) begin
      entry_q[victim_c] <= '{valid: 1'b1, vpn: wr_vpn, ppn: wr_ppn};
      if (!free_c) rr_ptr_q <= IDX_W'(rr_ptr_q + IDX_W'(1));
    end
  end

endmodule

// File: rtl/dtlb_lookup_stage.sv
// TLB lookup pipeline stage: translates memory addresses, stalls and refills on a miss.
// Optional hit/miss counters are built when TLB_PERF_CNT_EN is defined.
module dtlb_lookup_stage
  import tlb_pkg::*;
#(
  parameter  int unsigned DATA_W     = TLB_DATA_W,
  parameter  int unsigned REG_ADDR_W = 3,
  parameter  int unsigned PAGE_OFF_W = TLB_PAGE_OFF_W,
  parameter  int unsigned ENTRIES    = 4,
  localparam int unsigned VPN_W      = DATA_W - PAGE_OFF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_tlblookup,
  input  logic                  valid_input,
  input  logic                  mem_access_input,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [REG_ADDR_W-1:0] destReg_addr_input,
  input  logic                  we_input,
  input  logic                  flush,
  output logic                  stall_output,
  output logic                  valid_output,
  output logic                  mem_access_output,
  output logic [DATA_W-1:0]     tlblookup_result,
  output logic [REG_ADDR_W-1:0] destReg_addr_output,
  output logic                  we_output,
  output logic                  refill_req,
  output logic [VPN_W-1:0]      refill_vpn,
  input  logic                  refill_ack,
  input  logic [VPN_W-1:0]      refill_ppn,
  output logic [TLB_CNT_W-1:0]  hit_count,
  output logic [TLB_CNT_W-1:0]  miss_count
);

  tlb_state_e       state_q, state_d;
  logic [VPN_W-1:0] va_vpn_c;
  logic [VPN_W-1:0] refill_vpn_q;
  logic [VPN_W-1:0] hit_ppn_c;
  logic             hit_c;
  logic             lookup_c, miss_c, complete_c, fill_c;

  assign va_vpn_c   = alu_result[DATA_W-1:PAGE_OFF_W];
  assign lookup_c   = (state_q == LOOKUP);
  assign miss_c     = lookup_c & valid_input & mem_access_input & ~hit_c;
  assign complete_c = lookup_c & valid_input & (~mem_access_input | hit_c);
  assign fill_c     = (state_q == MISS_REQ) & refill_ack;

  // Both handshake signals decode live state; reset must silence them at once.
  assign stall_output = reset & ((state_q == MISS_REQ) | miss_c);
  assign refill_req   = (state_q == MISS_REQ);
  assign refill_vpn   = refill_vpn_q;

  tlb_cam #(
    .VPN_W  (VPN_W),
    .PPN_W  (VPN_W),
    .ENTRIES(ENTRIES)
  ) u_cam (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .lookup_vpn(va_vpn_c),
    .hit_c     (hit_c),
    .hit_ppn_c (hit_ppn_c),
    .wr_en     (fill_c),
    .wr_vpn    (refill_vpn_q),
    .wr_ppn    (refill_ppn)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOOKUP:   if (miss_c) state_d = MISS_REQ;
      MISS_REQ: if (refill_ack) state_d = LOOKUP;
      default:  state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOOKUP;
      refill_vpn_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_c) refill_vpn_q <= va_vpn_c;
    end
  end

  // Output register: completed instruction or a bubble, only on stage advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_output        <= 1'b0;
      mem_access_output   <= 1'b0;
      tlblookup_result    <= '0;
      destReg_addr_output <= '0;
      we_output           <= 1'b0;
    end else if (enable_tlblookup) begin
      if (complete_c) begin
        valid_output        <= 1'b1;
        mem_access_output   <= mem_access_input;
        tlblookup_result    <= mem_access_input ? {hit_ppn_c, alu_result[PAGE_OFF_W-1:0]}
                                                : alu_result;
        destReg_addr_output <= destReg_addr_input;
        we_output           <= we_input;
      end else begin
        valid_output        <= 1'b0;
        mem_access_output   <= 1'b0;
        tlblookup_result    <= '0;
        destReg_addr_output <= '0;
        we_output           <= 1'b0;
      end
    end
  end

`ifdef TLB_PERF_CNT_EN
  logic [TLB_CNT_W-1:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (enable_tlblookup & complete_c & mem_access_input) hit_count_q <= sat_inc(hit_count_q);
      if (miss_c) miss_count_q <= sat_inc(miss_count_q);
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
